// File: rtl/matrix_frame_loader_pkg.sv
// Shared definitions for the matrix frame bus: dimensions, FSM states and
// the element-to-bit-offset mapping used by every reader and writer of the bus.
package matrix_frame_loader_pkg;

    localparam int DIM_MAX  = 5;
    localparam int EW       = 8;
    localparam int FRAME_W  = DIM_MAX * DIM_MAX * EW;
    localparam int SIZE_MIN = 2;
    localparam int SIZE_MAX = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bit offset of element (r,c) inside the packed frame; row pitch is always DIM_MAX.
    function automatic int elem_lsb(input int r, input int c);
        return (DIM_MAX * r + c) * EW;
    endfunction

endpackage

// File: rtl/matrix_frame_loader.sv
// Streams row-major elements of an NxN matrix (N = 2..5) into a zero-padded
// 5x5 frame and presents it on a valid/ready handshake to the determinant stage.
module matrix_frame_loader #(
    parameter int DIM_MAX = matrix_frame_loader_pkg::DIM_MAX,
    parameter int EW      = matrix_frame_loader_pkg::EW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [2:0]                    size,
    input  logic                          in_valid,
    input  logic [EW-1:0]                 in_data,
    output logic                          in_ready,
    output logic [DIM_MAX*DIM_MAX*EW-1:0] matrix,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          err
);

    import matrix_frame_loader_pkg::*;

    state_t                          state_r;
    logic [2:0]                      n_r;
    logic [2:0]                      row_r;
    logic [2:0]                      col_r;
    logic [DIM_MAX*DIM_MAX*EW-1:0]   matrix_r;
    logic                            in_ready_r;
    logic                            out_valid_r;
    logic                            busy_r;
    logic                            err_r;

    logic                            legal_s;
    logic                            last_col_s;
    logic                            last_s;
    logic                            accept_s;

    // Decode size legality, end-of-row / end-of-frame and element acceptance.
    always_comb begin
        legal_s    = 1'b0;
        last_col_s = 1'b0;
        last_s     = 1'b0;
        accept_s   = 1'b0;
        if ((size >= 3'(SIZE_MIN)) && (size <= 3'(SIZE_MAX))) begin
            legal_s = 1'b1;
        end else begin
            legal_s = 1'b0;
        end
        if (col_r == (n_r - 3'd1)) begin
            last_col_s = 1'b1;
        end else begin
            last_col_s = 1'b0;
        end
        if (last_col_s && (row_r == (n_r - 3'd1))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
        if ((state_r == LOAD) && in_valid && in_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Loader FSM: frame register, row/column counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            n_r         <= 3'd0;
            row_r       <= 3'd0;
            col_r       <= 3'd0;
            matrix_r    <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (legal_s) begin
                            state_r    <= LOAD;
                            n_r        <= size;
                            row_r      <= 3'd0;
                            col_r      <= 3'd0;
                            matrix_r   <= '0;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end else begin
                            // Illegal size: flag it and leave the previous frame visible.
                            err_r <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        // Per-slot write decode; only the slot under (row_r,col_r) changes.
                        for (int r = 0; r < DIM_MAX; r++) begin
                            for (int c = 0; c < DIM_MAX; c++) begin
                                if ((row_r == 3'(r)) && (col_r == 3'(c))) begin
                                    matrix_r[elem_lsb(r, c) +: EW] <= in_data;
                                end
                            end
                        end
                        if (last_s) begin
                            state_r     <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else if (last_col_s) begin
                            col_r <= 3'd0;
                            row_r <= row_r + 3'd1;
                        end else begin
                            col_r <= col_r + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign matrix    = matrix_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Randomized scoreboard bench for matrix_frame_loader.
module tb_matrix_frame_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   size = 3'd0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'd0;
    logic         in_ready;
    logic [199:0] matrix;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         err;

    int           checks = 0;
    int           errors = 0;
    int           hs_cnt = 0;
    int           hs_base = 0;
    int           took = 0;
    bit           seen = 1'b0;
    logic [199:0] exp_q[$];
    logic [199:0] mon_exp;
    logic [199:0] last_frame = '0;
    logic [7:0]   el[25];

    matrix_frame_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .size      (size),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .matrix    (matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: element i of the row-major stream lands at row i/n, column i%n of a 5x5 grid.
    function automatic logic [199:0] build(input int n);
        logic [7:0] grid[5][5];
        logic [199:0] f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                grid[r][c] = 8'd0;
        for (int i = 0; i < n * n; i++)
            grid[i / n][i % n] = el[i];
        f = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                f = f | ({192'd0, grid[r][c]} << (8 * (5 * r + c)));
        return f;
    endfunction

    // Monitor: compare each newly presented frame with the oldest expectation.
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %0h expected none", matrix);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("frame", matrix, mon_exp);
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    // Count input handshakes as the DUT sees them.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) hs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        start = 1'b1;
        size = 3'(n);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_in_ready", {199'd0, in_ready}, 200'd1);
        chk("start_busy", {199'd0, busy}, 200'd1);
        tick();
    endtask

    // mode 0: in_valid held high, 1: toggling every cycle, else random gaps.
    task automatic stream(input int n_el, input int mode, output int acc);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < n_el && cyc < 400) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = ((cyc % 2) == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data = el[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        acc = idx;
        if (idx < n_el) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d elements expected %0d", idx, n_el);
        end
    endtask

    task automatic run_frame(input int n, input int mode);
        logic [199:0] e;
        int a;
        start_frame(n);
        e = build(n);
        exp_q.push_back(e);
        stream(n * n, mode, a);
        @(negedge clk);
        chk("last_out_valid", {199'd0, out_valid}, 200'd1);
        chk("last_in_ready", {199'd0, in_ready}, 200'd0);
        last_frame = e;
        tick();
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("release_out_valid", {199'd0, out_valid}, 200'd0);
        chk("release_busy", {199'd0, busy}, 200'd0);
        chk("release_matrix_kept", matrix, last_frame);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ill[4];
        int n;
        ill[0] = 1; ill[1] = 6; ill[2] = 0; ill[3] = 7;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {199'd0, out_valid}, 200'd0);
        chk("rst_in_ready", {199'd0, in_ready}, 200'd0);
        chk("rst_busy", {199'd0, busy}, 200'd0);
        chk("rst_err", {199'd0, err}, 200'd0);
        chk("rst_matrix", matrix, 200'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // size 4, elements 1..16, continuous valid
        for (int i = 0; i < 25; i++) el[i] = 8'(i + 1);
        run_frame(4, 0);
        chk("s4_00", {192'd0, matrix[7:0]}, 200'd1);
        chk("s4_10", {192'd0, matrix[47:40]}, 200'd5);
        chk("s4_33", {192'd0, matrix[151:144]}, 200'd16);
        chk("s4_row4", {160'd0, matrix[199:160]}, 200'd0);
        chk("s4_col4", {160'd0, matrix[39:32], matrix[79:72], matrix[119:112],
                        matrix[159:152], matrix[199:192]}, 200'd0);
        release_frame();

        // size 2, toggling valid, then held in HOLD with noise on start/in_valid
        el[0] = 8'd9; el[1] = 8'd8; el[2] = 8'd7; el[3] = 8'd6;
        hs_base = hs_cnt;
        run_frame(2, 1);
        chk("s2_bytes", matrix, {144'd0, 8'd6, 8'd7, 24'd0, 8'd8, 8'd9});
        start = 1'b1;
        size = 3'd3;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_out_valid", {199'd0, out_valid}, 200'd1);
            chk("hold_in_ready", {199'd0, in_ready}, 200'd0);
            chk("hold_err", {199'd0, err}, 200'd0);
            chk("hold_matrix", matrix, last_frame);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("s2_handshakes", 200'(hs_cnt - hs_base), 200'd4);
        release_frame();

        // Illegal sizes in IDLE
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            size = 3'(ill[k]);
            tick();
            start = 1'b0;
            @(negedge clk);
            chk("err_pulse", {199'd0, err}, 200'd1);
            chk("err_busy", {199'd0, busy}, 200'd0);
            chk("err_matrix", matrix, last_frame);
            tick();
            @(negedge clk);
            chk("err_one_cycle", {199'd0, err}, 200'd0);
            chk("err_busy2", {199'd0, busy}, 200'd0);
            tick();
        end

        // size 5, random elements with 0xFF in slot (4,4), random valid gaps
        for (int i = 0; i < 25; i++) el[i] = 8'($urandom_range(0, 255));
        el[24] = 8'hFF;
        run_frame(5, 2);
        chk("s5_44", {192'd0, matrix[199:192]}, 200'hFF);
        release_frame();

        // Reset in the middle of a size-4 frame
        for (int i = 0; i < 25; i++) el[i] = 8'($urandom_range(1, 255));
        start_frame(4);
        stream(7, 0, took);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_matrix", matrix, 200'd0);
        chk("midrst_out_valid", {199'd0, out_valid}, 200'd0);
        chk("midrst_busy", {199'd0, busy}, 200'd0);
        chk("midrst_in_ready", {199'd0, in_ready}, 200'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_frame = '0;
        tick();
        @(negedge clk);
        chk("postrst_out_valid", {199'd0, out_valid}, 200'd0);
        tick();
        for (int i = 0; i < 25; i++) el[i] = 8'($urandom_range(0, 255));
        run_frame(3, 0);
        release_frame();

        // Random frames
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(2, 5);
            for (int i = 0; i < 25; i++) el[i] = 8'($urandom_range(0, 255));
            run_frame(n, 2);
            release_frame();
        end

        chk("scoreboard_empty", 200'(exp_q.size()), 200'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_frame_loader.md
# matrix_frame_loader

- Sequential writer for the packed 200-bit matrix bus that the combinational determinant units read.
- Accepts a stream of 8-bit elements over a valid/ready handshake, in row-major order, for a square matrix of size N (2..5).
- Assembles the elements into a zero-padded 5×5 frame and holds it stable with a valid/ready output handshake until the determinant stage takes it.
- Sits between the host/bus interface and the determinant datapath.

## Interface
Parameters:
- DIM_MAX, 5, maximum matrix dimension (frame is DIM_MAX×DIM_MAX).
- EW, 8, element width in bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new frame; sampled only in IDLE.
- size  in  3  matrix dimension N for this frame; legal values 2..5.
- in_valid  in  1  in_data holds an element.
- in_data  in  EW  element value.
- in_ready  out  1  loader accepts an element this cycle.
- matrix  out  DIM_MAX*DIM_MAX*EW (200)  packed frame; element (r,c) at bits [(5r+c)*8 +: 8].
- out_valid  out  1  matrix is complete and stable.
- out_ready  in  1  consumer takes the frame.
- busy  out  1  state is not IDLE.
- err  out  1  one-cycle pulse when start is given with an illegal size.

## Operation
- State machine has three states: IDLE, LOAD, HOLD.
- IDLE:
  - start with size in 2..5: latch N, clear matrix to 0, zero the row and column counters (r,c), go to LOAD.
  - start with size 0, 1, 6 or 7: pulse err, stay in IDLE, leave matrix unchanged.
- LOAD:
  - in_ready=1. An element is accepted when in_valid && in_ready.
  - Accepted element is written to (r,c). Then c increments; when c==N-1, c wraps to 0 and r increments.
  - Acceptance with r==N-1 && c==N-1 is the last element: go to HOLD.
  - Positions with r≥N or c≥N stay 0.
- HOLD:
  - out_valid=1, in_ready=0, matrix frozen.
  - out_ready=1: go to IDLE. matrix keeps its contents in IDLE until the next legal start.
- start is ignored in LOAD and HOLD (no err, no restart).
- Counters are 3 bits wide and never exceed N-1.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, matrix=0, out_valid=0, in_ready=0, busy=0, err=0, counters=0.
- start accepted in cycle t: in_ready=1 and busy=1 from cycle t+1.
- err is asserted in cycle t+1 for one cycle.
- Last element accepted in cycle k: out_valid=1 and in_ready=0 from cycle k+1.
- out_ready seen in cycle h (out_valid=1): out_valid=0 and busy=0 from cycle h+1.
  - Minimum gap back to LOAD is one IDLE cycle.
- in_valid stalls in LOAD: no state change. The element is held off until in_valid returns.
- out_ready while not in HOLD has no effect.
- out_valid, when high, stays high with matrix stable until accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rst_n deasserted mid-LOAD or mid-HOLD:
  - Immediate return to IDLE with matrix=0.
  - The partial frame is discarded and no out_valid is produced.

## Structure
- Shared package:
  - DIM_MAX and EW.
  - State enum {IDLE, LOAD, HOLD}.
  - Function elem_lsb(r,c) = (5r+c)*EW for bus offsets, used identically by every reader of the bus.
  - Legal size range constants SIZE_MIN=2 and SIZE_MAX=5.
- No sub-module: one FSM, two counters and the frame register.
- Element writes are decoded per slot via elem_lsb.

## Test plan
- Reset, then start with size=4, then stream elements 1..16 with in_valid held high:
  - out_valid rises the cycle after element 16 is accepted.
  - (0,0)=1, (3,3)=16, (1,0)=5 at bits [47:40].
  - Row 4 and column 4 are all 0.
- size=2, elements 9,8,7,6, with in_valid toggling every other cycle:
  - Only 4 acceptances occur.
  - matrix[7:0]=9, [15:8]=8, [47:40]=7, [55:48]=6.
  - All other bits are 0.
- In HOLD, hold out_ready=0 for 10 cycles while driving start and in_valid:
  - out_valid stays 1, in_ready stays 0, matrix is unchanged.
  - err stays 0 throughout.
- In IDLE, start with size=1, then separately with size=6:
  - err pulses for exactly 1 cycle each time.
  - busy stays 0 and matrix is unchanged.
- size=5 frame of 25 elements with 0xFF in slot (4,4), then out_ready:
  - matrix[199:192]=0xFF.
  - After out_ready, the next cycle shows busy=0 and out_valid=0.
- Assert rst_n low after 7 of 16 elements of a size=4 frame:
  - State returns to IDLE, matrix=0, no out_valid.
  - A new start with size=3 and 9 elements then completes normally.
